// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave controller: key codes, time-entry
// state encoding and the seconds-tens limit used to validate an entry.
package microondas_pkg;

  localparam logic [3:0] KEY_CLEAR    = 4'hA;
  localparam logic [3:0] KEY_START    = 4'hB;
  localparam logic [3:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad level debouncer: 2-flop synchronizer, run-length counter and a
// registered one-shot that fires once per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic level_in,
  output logic evt_out
);

  localparam logic [7:0] CNT_TARGET = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       sync2_q;
  logic       stable_q;
  logic       stable_d;
  logic       evt_q;
  logic       evt_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Count samples that disagree with the accepted level; any agreement restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = 8'd0;
    evt_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if ((cnt_q + 8'd1) == CNT_TARGET) begin
        stable_d = sync2_q;
        evt_d    = sync2_q;
        cnt_d    = 8'd0;
      end else begin
        cnt_d    = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Synchronizer, counter and one-shot registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= level_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign evt_out = evt_q;

endmodule

// File: rtl/time_entry.sv
// Keypad time entry: shifts typed digits into an M:ST:SO BCD register and,
// on a valid START, pulses the countdown timer's active-low load strobe.
module time_entry
  import microondas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic [3:0] min_out,
  output logic [3:0] sec_tens_out,
  output logic [3:0] sec_ones_out,
  output logic       load_n,
  output logic [1:0] digit_count,
  output logic       entry_error
);

  logic       key_evt;
  state_e     state_q;
  state_e     state_d;
  logic [3:0] code_q;
  logic [3:0] code_d;
  logic [3:0] min_q;
  logic [3:0] min_d;
  logic [3:0] tens_q;
  logic [3:0] tens_d;
  logic [3:0] ones_q;
  logic [3:0] ones_d;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       load_n_q;
  logic       load_n_d;
  logic       err_q;
  logic       err_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .clear_n (clear_n),
    .level_in(key_pressed),
    .evt_out (key_evt)
  );

  // The code is only meaningful while a key is down, so keep the last one seen then.
  always_comb begin
    if (key_pressed) begin
      code_d = key_code;
    end else begin
      code_d = code_q;
    end
  end

  // Next-state, digit register and strobe logic.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    count_d = count_q;
    if (key_evt) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (key_evt && is_digit(code_q)) begin
          min_d   = tens_q;
          tens_d  = ones_q;
          ones_d  = code_q;
          count_d = 2'd1;
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (!key_evt) begin
          state_d = ST_ENTRY;
        end else if (is_digit(code_q)) begin
          if (count_q != 2'd3) begin
            min_d   = tens_q;
            tens_d  = ones_q;
            ones_d  = code_q;
            count_d = count_q + 2'd1;
          end else begin
            count_d = count_q;
          end
        end else if (code_q == KEY_CLEAR) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          count_d = 2'd0;
          state_d = ST_IDLE;
        end else if (code_q == KEY_START) begin
          if (tens_q <= MAX_SEC_TENS) begin
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // The timer keeps running after CLEAR; only busy dropping ends the run.
        if (!timer_busy) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          count_d = 2'd0;
          state_d = ST_IDLE;
        end else if (key_evt && (code_q == KEY_CLEAR)) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          count_d = 2'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_LOAD) begin
      load_n_d = 1'b0;
    end else begin
      load_n_d = 1'b1;
    end
  end

  // State, digit register, strobe and error flag.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      code_q   <= 4'd0;
      min_q    <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      count_q  <= 2'd0;
      load_n_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      min_q    <= min_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      count_q  <= count_d;
      load_n_q <= load_n_d;
      err_q    <= err_d;
    end
  end

  assign min_out      = min_q;
  assign sec_tens_out = tens_q;
  assign sec_ones_out = ones_q;
  assign digit_count  = count_q;
  assign load_n       = load_n_q;
  assign entry_error  = err_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed scenarios plus randomized key traffic
// compared against a value-level model of the entered time.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       key_pressed;
  logic [3:0] key_code;
  logic       timer_busy;
  logic [3:0] min_out;
  logic [3:0] sec_tens_out;
  logic [3:0] sec_ones_out;
  logic       load_n;
  logic [1:0] digit_count;
  logic       entry_error;

  time_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .timer_busy  (timer_busy),
    .min_out     (min_out),
    .sec_tens_out(sec_tens_out),
    .sec_ones_out(sec_ones_out),
    .load_n      (load_n),
    .digit_count (digit_count),
    .entry_error (entry_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the entered time as a decimal number, how many digits, and run status.
  int m_val   = 0;
  int m_cnt   = 0;
  int m_err   = 0;
  int m_loads = 0;
  bit m_run   = 1'b0;
  bit busy_v  = 1'b0;

  int loads_seen   = 0;
  int low_run      = 0;
  int max_low_run  = 0;

  always @(negedge clk) begin
    if (clear_n && !load_n) begin
      loads_seen++;
      low_run++;
      if (low_run > max_low_run) max_low_run = low_run;
    end else begin
      low_run = 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/min"},   int'(min_out),      m_val / 100);
    check({tag, "/tens"},  int'(sec_tens_out), (m_val / 10) % 10);
    check({tag, "/ones"},  int'(sec_ones_out), m_val % 10);
    check({tag, "/count"}, int'(digit_count),  m_cnt);
    check({tag, "/err"},   int'(entry_error),  m_err);
    check({tag, "/loads"}, loads_seen,         m_loads);
    check({tag, "/load_n"}, int'(load_n),      1);
  endtask

  task automatic model_key(input int code);
    m_err = 0;
    if (m_run) begin
      if (code == 10) begin
        m_val = 0;
        m_cnt = 0;
      end
    end else if (m_cnt == 0) begin
      if (code <= 9) begin
        m_val = code;
        m_cnt = 1;
      end
    end else if (code <= 9) begin
      if (m_cnt < 3) begin
        m_val = (m_val * 10 + code) % 1000;
        m_cnt++;
      end
    end else if (code == 10) begin
      m_val = 0;
      m_cnt = 0;
    end else if (code == 11) begin
      if (((m_val / 10) % 10) <= 5) begin
        m_loads++;
        if (busy_v) begin
          m_run = 1'b1;
        end else begin
          m_val = 0;
          m_cnt = 0;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic press(input int code, input string tag);
    @(negedge clk);
    key_code    = 4'(code);
    key_pressed = 1'b1;
    repeat (12) @(negedge clk);
    model_key(code);
    check_all(tag);
    key_pressed = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    key_code    = 4'($urandom_range(0, 15));
    key_pressed = 1'b1;
    repeat (len) @(negedge clk);
    key_pressed = 1'b0;
    repeat (10) @(negedge clk);
    check_all("glitch");
  endtask

  task automatic set_busy(input bit val);
    @(negedge clk);
    timer_busy = val;
    busy_v     = val;
    if (!val && m_run) begin
      m_run = 1'b0;
      m_val = 0;
      m_cnt = 0;
    end
    repeat (4) @(negedge clk);
    check_all("busy");
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    m_val = 0;
    m_cnt = 0;
    m_err = 0;
    m_run = 1'b0;
    check_all("reset_mid");
    @(negedge clk);
    clear_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int edges;
    bit found;
    int c;
    int r;

    clear_n     = 1'b0;
    key_pressed = 1'b0;
    key_code    = 4'd0;
    timer_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    clear_n = 1'b1;
    repeat (3) @(negedge clk);

    press(11, "start_idle");

    press(1, "k1");
    press(2, "k2");
    press(3, "k3");
    press(11, "start_ok");

    press(4, "k4");
    press(5, "k5");
    press(6, "k6");
    press(7, "k7_ovf");
    press(10, "clear");

    press(9, "k9");
    press(0, "k0");
    press(11, "start_bad");
    press(5, "k5_after_err");
    press(10, "clear2");

    press(1, "b1");
    press(2, "b2");
    set_busy(1'b1);
    press(11, "b_start");
    press(5, "b_digit");
    press(11, "b_start2");
    set_busy(1'b0);

    press(4, "r4");
    press(5, "r5");
    do_reset();

    // Bounces of 3 high samples, then a stable press of code 8.
    key_code = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      key_pressed = 1'b1;
      repeat (3) @(negedge clk);
      key_pressed = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    key_pressed = 1'b1;
    edges = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (sec_ones_out == 4'd8) found = 1'b1;
    end
    check("latency_edges", edges, 7);
    repeat (13) @(negedge clk);
    model_key(8);
    check_all("debounce_hold");
    key_pressed = 1'b0;
    repeat (10) @(negedge clk);

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch($urandom_range(1, 3));
      end else if (r == 1) begin
        set_busy(!busy_v);
      end else begin
        c = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) c = 11;
        press(c, "rand");
      end
    end

    check("load_pulse_len", max_low_run, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_entry.md
# time_entry

Keypad time-entry block for the microwave controller: debounces the keypad strobe, decodes key codes, and shifts typed digits into a three-digit BCD register M:ST:SO (typing 1,2,3 gives 1:23). On a valid START it drives the countdown timer's parallel-load interface (BCD digits plus a one-cycle active-low load pulse). It is the writer side of the timer's load port.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples of equal level needed to accept a press or a release (legal range 1–255).
- clk  input  1  system clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- key_pressed  input  1  raw keypad "any key down" level (asynchronous).
- key_code  input  4  key identity, stable while key_pressed is high: 0–9 digit, 4'hA CLEAR, 4'hB START, 4'hC–4'hF ignored.
- timer_busy  input  1  high while the timer counts down.
- min_out, sec_tens_out, sec_ones_out  output  4 each  BCD digits to the timer's parallel-load inputs.
- load_n  output  1  active-low load strobe to the timer, registered.
- digit_count  output  2  number of digits entered (0–3).
- entry_error  output  1  sticky flag: last START was rejected.

## Operation
- Sync: key_pressed passes through a 2-flop synchronizer. The debouncer counts consecutive equal samples.
  - A press is accepted when the synced level has been high for DEBOUNCE_CYCLES samples. This raises a one-cycle internal key_evt and latches key_code.
  - No further key_evt is produced until the synced level has been low for DEBOUNCE_CYCLES samples. Holding a key produces exactly one event.
- States: IDLE, ENTRY, LOAD, RUN.
  - IDLE: digit_count=0, digits 0.
    - Digit → ENTRY.
    - CLEAR → stay.
    - START → ignored (no load, no error).
  - ENTRY:
    - Digit with digit_count<3: shift min←sec_tens, sec_tens←sec_ones, sec_ones←digit; increment digit_count.
    - Digit with digit_count=3: ignored; register and count unchanged.
    - CLEAR: zero the digits, digit_count=0 → IDLE.
    - START with sec_tens_out≤5 → LOAD.
    - START with sec_tens_out>5: set entry_error, stay in ENTRY, register unchanged.
  - LOAD: load_n=0 for exactly one cycle, then → RUN. Digits are held stable during this cycle.
  - RUN: all digit and START keys are ignored.
    - CLEAR zeroes the digits and digit_count but stays in RUN. It does not stop the timer.
    - → IDLE on the first cycle timer_busy is sampled low, after at least one cycle in RUN. Digits are zeroed on that transition.
- entry_error: set only by a rejected START. Cleared by the next key_evt of any kind, and by reset.
- Codes 4'hC–4'hF produce key_evt but no action. They do clear entry_error.
- Reset mid-operation (any state, including LOAD) → IDLE immediately, load_n=1, and the debouncer returns to the released/armed condition.

## Timing
- Reset values: min_out=sec_tens_out=sec_ones_out=0, digit_count=0, load_n=1, entry_error=0, state IDLE, debounce counter 0, synchronizer 0.
- Press latency: for a clean rising key_pressed before clock edge E0, key_evt is high in the cycle after edge E0+1+DEBOUNCE_CYCLES. Digit/state outputs update on the next edge, 2+DEBOUNCE_CYCLES+1 edges after E0 (7 edges at default).
- START to load: the key_evt edge enters LOAD, so load_n is low for one full cycle starting at that edge and returns high on the following edge. Digits are valid for the whole low cycle.
- Any bounce (level change) restarts the debounce count. Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package/include (microondas_pkg) holds:
  - the key-code constants KEY_CLEAR=4'hA and KEY_START=4'hB;
  - the 2-bit state encoding (IDLE=0, ENTRY=1, LOAD=2, RUN=3);
  - the constant MAX_SEC_TENS=5.
- One sub-module, key_debounce: synchronizer, counter and one-shot. Parameter DEBOUNCE_CYCLES; ports clk, clear_n, level_in, evt_out.
- The top level contains the state machine, shift register, validation and load_n register.

## Test plan
- Reset/idle: assert clear_n=0 mid-entry → all outputs at reset values, load_n=1. START in IDLE → no load_n pulse, entry_error=0.
- Entry and load: keys 1,2,3 then START, timer_busy held low → digits 1:2:3, digit_count=3, one load_n low cycle. Return to IDLE one cycle later (busy low), digits 0.
- Overflow/clear: keys 4,5,6,7 → 4:5:6 (7 ignored). CLEAR → 0:0:0, digit_count=0.
- Invalid: keys 9,0 then START (0:9:0) → no load_n pulse, entry_error=1, stays in ENTRY. Next key 5 → entry_error=0, digits 9:0:5.
- Debounce: DEBOUNCE_CYCLES=4. key_pressed bounces with 3-cycle highs, then is held high 20 cycles with code 8 → exactly one event, sec_ones=8, first update 7 edges after the stable rise.
- Busy: after a load, hold timer_busy=1 and press 5 and START → no change, no second load_n pulse. Drop timer_busy → IDLE.
